// File: rtl/descrambler_pkg.sv
// Shared constants and state encodings for the 64b/66b descrambler and its
// companion scrambler.
package descrambler_pkg;

    // Idle control block: header 2'b10, block type 8'h1E, all-idle payload.
    localparam logic [65:0] IDLE_BLOCK = 66'h21E00000000000000;

    // Taps of x^58 + x^39 + 1 expressed as positions in the shift register.
    // state[0] holds the bit received 58 bits ago and state[19] the one 39 ago.
    localparam int TAP_A = 19;
    localparam int TAP_B = 0;

    // Idle checker thresholds: consecutive matches to lock and
    // consecutive mismatches to drop lock.
    localparam int LOCK_THRESH   = 4;
    localparam int UNLOCK_THRESH = 16;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } warmup_state_e;

    typedef enum logic {
        UNLOCK = 1'b0,
        LOCK   = 1'b1
    } idle_state_e;

endpackage

// File: rtl/descrambler_idle_checker.sv
// Idle-pattern checker: locks onto a stream of idle blocks and counts
// idle mismatches while locked.
//
// state  | meaning
// UNLOCK | hunting; counting consecutive idle matches toward lock
// LOCK   | locked; mismatches are counted, a long mismatch run drops lock
module idle_pattern_checker
    import descrambler_pkg::*;
#(
    parameter int LEN_CODED_BLOCK = 66,
    parameter int NB_ERR_CNT      = 16
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_mode,
    input  logic                       i_clear,
    input  logic                       i_blk_valid,
    input  logic [LEN_CODED_BLOCK-1:0] i_blk_data,
    output logic [NB_ERR_CNT-1:0]      o_err_count,
    output logic                       o_lock
);

    localparam int MATCH_W = $clog2(LOCK_THRESH + 1);
    localparam int MISS_W  = $clog2(UNLOCK_THRESH + 1);

    idle_state_e         st_q, st_d;
    logic [MATCH_W-1:0]  match_q, match_d;
    logic [MISS_W-1:0]   miss_q, miss_d;
    logic [NB_ERR_CNT-1:0] err_q, err_d;
    logic                is_idle;
    logic                err_inc;

    assign is_idle = (i_blk_data == LEN_CODED_BLOCK'(IDLE_BLOCK));

    // State and run-length registers
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            st_q    <= UNLOCK;
            match_q <= '0;
            miss_q  <= '0;
        end else begin
            st_q    <= st_d;
            match_q <= match_d;
            miss_q  <= miss_d;
        end
    end

    // Next-state and run-length update
    always_comb begin
        st_d    = st_q;
        match_d = match_q;
        miss_d  = miss_q;
        if (!i_mode) begin
            st_d    = UNLOCK;
            match_d = '0;
            miss_d  = '0;
        end else if (i_blk_valid) begin
            case (st_q)
                UNLOCK: begin
                    if (is_idle) begin
                        if (match_q == MATCH_W'(LOCK_THRESH - 1)) begin
                            st_d    = LOCK;
                            match_d = '0;
                        end else begin
                            match_d = match_q + 1'b1;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCK: begin
                    if (is_idle) begin
                        miss_d = '0;
                    end else if (miss_q == MISS_W'(UNLOCK_THRESH - 1)) begin
                        st_d   = UNLOCK;
                        miss_d = '0;
                    end else begin
                        miss_d = miss_q + 1'b1;
                    end
                end
                default: st_d = UNLOCK;
            endcase
        end
    end

    // Outputs decoded from the current state
    always_comb begin
        o_lock  = (st_q == LOCK);
        err_inc = i_mode && i_blk_valid && (st_q == LOCK) && !is_idle;
    end

    // Saturating idle error counter; clear wins over increment
    always_comb begin
        err_d = err_q;
        if (i_clear) begin
            err_d = '0;
        end else if (err_inc && (err_q != '1)) begin
            err_d = err_q + 1'b1;
        end
    end

    // Idle error counter register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err_count = err_q;

endmodule

// File: rtl/descrambler.sv
// Self-synchronous 64b/66b descrambler (x^58 + x^39 + 1) with sync-header
// error counting and an idle-pattern lock checker.
//
// state  | meaning
// WARMUP | shift register not yet filled from the line; output not trusted
// RUN    | at least one full payload shifted in; output is valid
module descrambler
    import descrambler_pkg::*;
#(
    parameter int                      LEN_SCRAMBLER   = 58,
    parameter int                      LEN_CODED_BLOCK = 66,
    parameter int                      NB_SH           = 2,
    parameter int                      NB_ERR_CNT      = 16,
    parameter logic [LEN_SCRAMBLER-1:0] SEED           = '0
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic                       i_bypass,
    input  logic                       i_idle_pattern_mode,
    input  logic                       i_clear_counters,
    input  logic [LEN_CODED_BLOCK-1:0] i_data,
    output logic [LEN_CODED_BLOCK-1:0] o_data,
    output logic                       o_valid,
    output logic [NB_ERR_CNT-1:0]      o_sh_error_count,
    output logic [NB_ERR_CNT-1:0]      o_idle_error_count,
    output logic                       o_idle_lock
);

    localparam int NB_PAYLOAD = LEN_CODED_BLOCK - NB_SH;

    logic [LEN_SCRAMBLER-1:0]   scr_q, scr_d, scr_next;
    logic [LEN_CODED_BLOCK-1:0] data_q, data_d, descr;
    logic                       valid_q, valid_d;
    warmup_state_e              wu_q, wu_d;
    logic                       run;
    logic [NB_ERR_CNT-1:0]      sh_cnt_q, sh_cnt_d;
    logic [NB_SH-1:0]           header;
    logic                       sh_bad;

    // Bit-serial descramble of the payload, MSB first; the header passes through
    always_comb begin
        logic [LEN_SCRAMBLER-1:0] s;
        s     = scr_q;
        descr = i_data;
        for (int i = NB_PAYLOAD - 1; i >= 0; i--) begin
            descr[i] = i_data[i] ^ s[TAP_A] ^ s[TAP_B];
            s        = {i_data[i], s[LEN_SCRAMBLER-1:1]};
        end
        scr_next = s;
    end

    // Warm-up state register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wu_q <= WARMUP;
        end else begin
            wu_q <= wu_d;
        end
    end

    // Warm-up next state: one real block fills all 58 stages; bypass never reverts
    always_comb begin
        wu_d = wu_q;
        if (i_enable && !i_bypass) begin
            wu_d = RUN;
        end
    end

    // Warm-up output decode
    always_comb begin
        run = (wu_q == RUN);
    end

    // Datapath next values; state and data hold when not enabled
    always_comb begin
        scr_d   = scr_q;
        data_d  = data_q;
        valid_d = 1'b0;
        if (i_enable) begin
            valid_d = i_bypass || run;
            if (i_bypass) begin
                data_d = i_data;
            end else begin
                data_d = descr;
                scr_d  = scr_next;
            end
        end
    end

    // Sync header check: all-zeros or all-ones is not a legal header
    always_comb begin
        header   = i_data[LEN_CODED_BLOCK-1 -: NB_SH];
        sh_bad   = i_enable && ((header == '0) || (header == '1));
        sh_cnt_d = sh_cnt_q;
        if (i_clear_counters) begin
            sh_cnt_d = '0;
        end else if (sh_bad && (sh_cnt_q != '1)) begin
            sh_cnt_d = sh_cnt_q + 1'b1;
        end
    end

    // Datapath and sync-header counter registers
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            scr_q    <= SEED;
            data_q   <= '0;
            valid_q  <= 1'b0;
            sh_cnt_q <= '0;
        end else begin
            scr_q    <= scr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            sh_cnt_q <= sh_cnt_d;
        end
    end

    // The checker sees the block as it is being registered so that the lock
    // flag and error count line up with the block shown on o_data.
    idle_pattern_checker #(
        .LEN_CODED_BLOCK (LEN_CODED_BLOCK),
        .NB_ERR_CNT      (NB_ERR_CNT)
    ) u_idle_checker (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_mode      (i_idle_pattern_mode),
        .i_clear     (i_clear_counters),
        .i_blk_valid (valid_d),
        .i_blk_data  (data_d),
        .o_err_count (o_idle_error_count),
        .o_lock      (o_idle_lock)
    );

    assign o_data           = data_q;
    assign o_valid          = valid_q;
    assign o_sh_error_count = sh_cnt_q;

endmodule

// File: tb/tb_descrambler.sv
// Directed bench for the descrambler: scrambler loopback, idle lock,
// sync header counting/saturation, bypass, clear and mid-stream reset.
module tb_descrambler;
    import descrambler_pkg::*;

    localparam logic [57:0] DSEED = 58'h3FF_FFFF_FFFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic        en, byp, idle_mode, clr;
    logic [65:0] din;
    logic [65:0] dout, dout4;
    logic        vld, vld4;
    logic [15:0] sh_cnt, idle_cnt;
    logic [3:0]  sh_cnt4, idle_cnt4;
    logic        lock, lock4;

    int n_vec = 0;
    int n_err = 0;

    logic [57:0] sc_state;
    logic [65:0] pl, sc;

    descrambler #(.SEED(DSEED)) dut (
        .i_clock(clk), .i_reset(rst_n), .i_enable(en), .i_bypass(byp),
        .i_idle_pattern_mode(idle_mode), .i_clear_counters(clr), .i_data(din),
        .o_data(dout), .o_valid(vld), .o_sh_error_count(sh_cnt),
        .o_idle_error_count(idle_cnt), .o_idle_lock(lock)
    );

    descrambler #(.NB_ERR_CNT(4), .SEED(DSEED)) dut4 (
        .i_clock(clk), .i_reset(rst_n), .i_enable(en), .i_bypass(byp),
        .i_idle_pattern_mode(idle_mode), .i_clear_counters(clr), .i_data(din),
        .o_data(dout4), .o_valid(vld4), .o_sh_error_count(sh_cnt4),
        .o_idle_error_count(idle_cnt4), .o_idle_lock(lock4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference scrambler (seed 0): transmitted bit = in ^ s[19] ^ s[0]
    task automatic scramble(input logic [65:0] p, output logic [65:0] s);
        logic b;
        s = p;
        for (int i = 63; i >= 0; i--) begin
            b = p[i] ^ sc_state[TAP_A] ^ sc_state[TAP_B];
            s[i] = b;
            sc_state = {b, sc_state[57:1]};
        end
    endtask

    function automatic logic [65:0] rand_block();
        logic [65:0] b;
        b[63:32] = $urandom;
        b[31:0]  = $urandom;
        b[65:64] = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
        return b;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; byp = 1'b0; idle_mode = 1'b0; clr = 1'b0; din = '0;
        #2;
        n_vec++; if (dout !== 66'h0) begin n_err++; $display("FAIL reset_data got %h exp 0", dout); end
        n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", vld); end
        n_vec++; if (sh_cnt !== 16'h0 || idle_cnt !== 16'h0) begin n_err++; $display("FAIL reset_counts got %h/%h exp 0/0", sh_cnt, idle_cnt); end
        n_vec++; if (lock !== 1'b0) begin n_err++; $display("FAIL reset_lock got %b exp 0", lock); end
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_loopback();
        logic [65:0] p;
        logic [65:0] s;
        en = 1'b1; byp = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            p = rand_block();
            scramble(p, s);
            din = s;
            step();
            if (k == 1) begin
                n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL loop_first_valid got %b exp 0", vld); end
            end else begin
                n_vec++; if (vld !== 1'b1) begin n_err++; $display("FAIL loop_valid blk %0d got %b exp 1", k, vld); end
                n_vec++; if (dout !== p) begin n_err++; $display("FAIL loop_data blk %0d got %h exp %h", k, dout, p); end
            end
        end
        n_vec++; if (sh_cnt !== 16'h0) begin n_err++; $display("FAIL loop_sh_count got %0d exp 0", sh_cnt); end
    endtask

    task automatic test_idle();
        logic [65:0] s;
        idle_mode = 1'b1; en = 1'b1; byp = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            scramble(IDLE_BLOCK, s); din = s; step();
            n_vec++; if (lock !== (k == 4)) begin n_err++; $display("FAIL idle_lock blk %0d got %b exp %b", k, lock, (k == 4)); end
        end
        scramble(IDLE_BLOCK ^ 66'h1, s); din = s; step();
        n_vec++; if (dout !== (IDLE_BLOCK ^ 66'h1)) begin n_err++; $display("FAIL idle_corrupt_data got %h exp %h", dout, IDLE_BLOCK ^ 66'h1); end
        n_vec++; if (idle_cnt !== 16'd1) begin n_err++; $display("FAIL idle_err_one got %0d exp 1", idle_cnt); end
        n_vec++; if (lock !== 1'b1) begin n_err++; $display("FAIL idle_lock_held got %b exp 1", lock); end
        scramble(IDLE_BLOCK, s); din = s; step();
        for (int j = 1; j <= 16; j++) begin
            scramble(IDLE_BLOCK ^ 66'h100, s); din = s; step();
            n_vec++; if (lock !== (j < 16)) begin n_err++; $display("FAIL idle_unlock run %0d got %b exp %b", j, lock, (j < 16)); end
        end
        n_vec++; if (idle_cnt !== 16'd17) begin n_err++; $display("FAIL idle_err_total got %0d exp 17", idle_cnt); end
        n_vec++; if (idle_cnt4 !== 4'd15) begin n_err++; $display("FAIL idle_err_sat got %0d exp 15", idle_cnt4); end
        idle_mode = 1'b0;
    endtask

    task automatic test_sync_header();
        logic [1:0] hdr [4];
        hdr[0] = 2'b00; hdr[1] = 2'b11; hdr[2] = 2'b01; hdr[3] = 2'b10;
        en = 1'b0; clr = 1'b1; step(); clr = 1'b0;
        n_vec++; if (sh_cnt !== 16'h0 || idle_cnt !== 16'h0) begin n_err++; $display("FAIL sh_clear got %0d/%0d exp 0/0", sh_cnt, idle_cnt); end
        en = 1'b1; byp = 1'b1;
        for (int k = 0; k < 4; k++) begin
            din = {hdr[k], 64'h0123_4567_89AB_CDE0 + 64'(k)};
            step();
            n_vec++; if (vld !== 1'b1 || dout !== din) begin n_err++; $display("FAIL sh_bypass_out %0d got %b/%h exp 1/%h", k, vld, dout, din); end
        end
        n_vec++; if (sh_cnt !== 16'd2 || sh_cnt4 !== 4'd2) begin n_err++; $display("FAIL sh_count got %0d/%0d exp 2/2", sh_cnt, sh_cnt4); end
        en = 1'b0; din = {2'b00, 64'hFFFF_0000_FFFF_0000}; step();
        n_vec++; if (sh_cnt !== 16'd2) begin n_err++; $display("FAIL sh_hold got %0d exp 2", sh_cnt); end
        n_vec++; if (vld !== 1'b0 || dout !== {2'b10, 64'h0123_4567_89AB_CDE3}) begin n_err++; $display("FAIL idle_hold got %b/%h exp 0/%h", vld, dout, {2'b10, 64'h0123_4567_89AB_CDE3}); end
        en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            din = {((k % 2) == 0) ? 2'b00 : 2'b11, 64'(k)};
            step();
        end
        n_vec++; if (sh_cnt4 !== 4'd15) begin n_err++; $display("FAIL sh_saturate got %0d exp 15", sh_cnt4); end
        n_vec++; if (sh_cnt !== 16'd22) begin n_err++; $display("FAIL sh_count_wide got %0d exp 22", sh_cnt); end
    endtask

    task automatic test_bypass();
        logic [65:0] p;
        logic [65:0] s;
        en = 1'b1; byp = 1'b0;
        p = rand_block(); scramble(p, s); din = s; step();
        n_vec++; if (vld !== 1'b1) begin n_err++; $display("FAIL byp_run_kept got %b exp 1", vld); end
        byp = 1'b1; din = 66'h1_2345_6789_ABCD_EF01; step();
        n_vec++; if (dout !== 66'h1_2345_6789_ABCD_EF01 || vld !== 1'b1) begin n_err++; $display("FAIL byp_data got %b/%h exp 1/%h", vld, dout, 66'h1_2345_6789_ABCD_EF01); end
        byp = 1'b0; p = rand_block(); scramble(p, s); din = s; step();
        n_vec++; if (dout !== p || vld !== 1'b1) begin n_err++; $display("FAIL byp_state_held got %b/%h exp 1/%h", vld, dout, p); end
    endtask

    task automatic test_clear();
        en = 1'b1; byp = 1'b1; clr = 1'b1; din = {2'b00, 64'h5555_AAAA_5555_AAAA};
        step();
        clr = 1'b0;
        n_vec++; if (sh_cnt !== 16'h0 || sh_cnt4 !== 4'h0) begin n_err++; $display("FAIL clr_priority got %0d/%0d exp 0/0", sh_cnt, sh_cnt4); end
        n_vec++; if (idle_cnt !== 16'h0 || idle_cnt4 !== 4'h0) begin n_err++; $display("FAIL clr_idle got %0d/%0d exp 0/0", idle_cnt, idle_cnt4); end
        byp = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [65:0] p;
        logic [65:0] s;
        en = 1'b1; byp = 1'b0;
        p = rand_block(); scramble(p, s); din = s; step();
        n_vec++; if (dout !== p || vld !== 1'b1) begin n_err++; $display("FAIL pre_reset got %b/%h exp 1/%h", vld, dout, p); end
        din = {2'b11, 64'hDEAD_BEEF_0000_0001};
        #3;
        rst_n = 1'b0; en = 1'b0;
        #1;
        n_vec++; if (dout !== 66'h0 || vld !== 1'b0) begin n_err++; $display("FAIL mid_reset_out got %b/%h exp 0/0", vld, dout); end
        n_vec++; if (sh_cnt !== 16'h0 || lock !== 1'b0) begin n_err++; $display("FAIL mid_reset_misc got %0d/%b exp 0/0", sh_cnt, lock); end
        #2;
        rst_n = 1'b1;
        en = 1'b1;
        p = rand_block(); scramble(p, s); din = s; step();
        n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL post_reset_warmup got %b exp 0", vld); end
        p = rand_block(); scramble(p, s); din = s; step();
        n_vec++; if (dout !== p || vld !== 1'b1) begin n_err++; $display("FAIL post_reset_run got %b/%h exp 1/%h", vld, dout, p); end
        en = 1'b0;
    endtask

    initial begin
        sc_state = '0;
        test_reset();
        test_loopback();
        test_idle();
        test_sync_header();
        test_bypass();
        test_clear();
        test_reset_mid();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/descrambler.md
DESCRAMBLER -- requirements
Module: descrambler

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- LEN_SCRAMBLER, 58, descrambler state length
- LEN_CODED_BLOCK, 66, coded block width
- NB_SH, 2, sync header width
- NB_ERR_CNT, 16, error counter width
- SEED, 0, state value loaded on reset
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
- i_clock, in, 1, sole clock
- i_reset, in, 1, asynchronous active-low reset
- i_enable, in, 1, block strobe; one 66-bit block per enabled cycle
- i_bypass, in, 1, pass i_data unmodified
- i_idle_pattern_mode, in, 1, enable idle-pattern checker
- i_clear_counters, in, 1, synchronous clear of both error counters
- i_data, in, 66, scrambled block; [65:64] = sync header
- o_data, out, 66, descrambled block
- o_valid, out, 1, o_data qualifier
- o_sh_error_count, out, NB_ERR_CNT, invalid sync headers seen
- o_idle_error_count, out, NB_ERR_CNT, idle-block mismatches while locked
- o_idle_lock, out, 1, idle checker locked

Function
REQ-003 Polynomial SHALL be x^58+x^39+1, self-synchronous; bits SHALL be processed from i_data[63] down to [0].
REQ-004 For each bit: out = in ^ state[19] ^ state[0]; next state = {in, state[57:1]}. The received (scrambled) bit SHALL be the bit shifted in.
REQ-005 Sync header [65:64] SHALL pass unmodified and SHALL NOT enter the state.
REQ-006 Latency SHALL be exactly 1 cycle: block sampled at edge N appears on o_data after edge N.
REQ-007 With i_enable=0, o_data, o_valid=0, state, counters and checker SHALL hold. o_data holds its last value.
REQ-008 With i_enable=1 and i_bypass=1, o_data SHALL equal i_data and state SHALL hold.
REQ-009 Warm-up FSM states SHALL be WARMUP and RUN. Reset enters WARMUP. The first enabled non-bypass block moves WARMUP->RUN, since 64 bits exceed 58 stages.
REQ-010 o_valid SHALL be registered as i_enable && (i_bypass || state==RUN before the edge). The first non-bypass block after reset SHALL be output with o_valid=0.
REQ-011 On any enabled cycle, bypass or not, a sync header of 2'b00 or 2'b11 SHALL increment o_sh_error_count.
REQ-012 IDLE_BLOCK SHALL be 66'h21E00000000000000.
REQ-013 Checker FSM states SHALL be UNLOCK, LOCK.
- Evaluates only blocks with o_valid=1 while i_idle_pattern_mode=1.
- UNLOCK->LOCK after 4 consecutive descrambled blocks equal to IDLE_BLOCK; any mismatch resets the match count.
- In LOCK, each mismatch increments o_idle_error_count.
- 16 consecutive mismatches return the FSM to UNLOCK; a match clears the mismatch run.
- i_idle_pattern_mode=0 forces UNLOCK and clears both run counts.
REQ-014 o_idle_lock SHALL be 1 exactly in LOCK.
REQ-015 Both error counters SHALL saturate at 2^NB_ERR_CNT-1 and SHALL NOT wrap.
REQ-016 i_clear_counters SHALL zero both counters next edge and take priority over a simultaneous increment. It SHALL NOT affect the FSMs.
REQ-017 i_bypass toggling mid-stream SHALL NOT return the warm-up FSM to WARMUP.

Reset
REQ-018 While i_reset=0, asynchronously:
- state=SEED
- o_data=0, o_valid=0
- both counters=0
- warm-up FSM=WARMUP; checker=UNLOCK with run counts 0
REQ-019 Reset asserted mid-stream SHALL discard the in-flight block. The first post-release non-bypass block SHALL again have o_valid=0.

Structure
REQ-020 A shared package SHALL hold: IDLE_BLOCK, the tap indices (19, 0), the lock and unlock thresholds (4, 16), and the FSM state encodings. The existing scrambler SHALL reuse IDLE_BLOCK from it.
REQ-021 The idle checker SHALL be one sub-module, idle_pattern_checker, holding the checker FSM and o_idle_error_count.

Verification
REQ-022 Required directed scenarios:
- Loopback: existing scrambler (SEED=0) -> descrambler (SEED=58'h3FF_FFFF_FFFF_FFFF), 100 random blocks -> blocks 2..100 match scrambler input bit-exact with o_valid=1; block 1 has o_valid=0.
- Idle: scrambled IDLE_BLOCK stream, i_idle_pattern_mode=1 -> o_idle_lock=1 after the 4th valid block; then flip one payload bit -> o_idle_error_count=1 and lock held; 16 corrupted blocks -> o_idle_lock=0.
- Sync header: headers 00, 11, 01, 10 on enabled cycles -> o_sh_error_count=2; with NB_ERR_CNT=4, 20 bad headers -> count 15.
- Bypass: i_bypass=1, i_data=66'h1_2345_6789_ABCD_EF01 -> same value next cycle with o_valid=1; state unchanged.
- Clear and reset: i_clear_counters together with a bad header -> counter 0. i_reset low mid-stream -> all outputs 0 immediately, and the next block has o_valid=0.
